// File: rtl/pulse_handshake_gen.sv
// Turns single-cycle event pulses into a VALID/READY event stream. Pending events are
// counted so bursts survive consumer stalls, and each presented event carries a wrapping tag.
//
// state | meaning
// IDLE  | nothing pending, Ev_Valid low
// VALID | an event is presented and held until accepted
// GAP   | forced idle spacing after an accept, Ev_Valid low
module pulse_handshake_gen #(
    parameter int CNT_W      = 4,
    parameter int SEQ_W      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             Event_Pulse,
    input  logic             Clear,
    output logic             Ev_Valid,
    input  logic             Ev_Ready,
    output logic [SEQ_W-1:0] Ev_Seq,
    output logic [CNT_W-1:0] Pending,
    output logic             Overflow,
    output logic             Busy
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic accept;
    logic saturated;
    logic inc;

    always_comb begin
        accept    = (state_q == VALID) && Ev_Ready;
        saturated = (pend_q == PEND_MAX);
        // At saturation a simultaneous accept frees a slot, so the pulse still counts.
        inc       = Event_Pulse && (!saturated || accept);

        pend_d  = pend_q;
        seq_d   = seq_q;
        gap_d   = gap_q;
        ovf_d   = ovf_q;
        state_d = state_q;

        if (inc && !accept) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (!inc && accept) begin
            pend_d = pend_q - CNT_W'(1);
        end

        if (Event_Pulse && saturated && !accept) begin
            ovf_d = 1'b1;
        end

        if (accept) begin
            seq_d = seq_q + SEQ_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (Event_Pulse || (pend_q != '0)) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (accept) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = (pend_d != '0) ? VALID : IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_CYCLES);
                    end
                end
            end
            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = (pend_d != '0) ? VALID : IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase

        // Clear wins over everything but reset; the tag is deliberately left untouched.
        if (Clear) begin
            pend_d  = '0;
            ovf_d   = 1'b0;
            seq_d   = seq_q;
            gap_d   = '0;
            state_d = IDLE;
        end

        valid_d = (state_d == VALID);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            pend_q  <= '0;
            seq_q   <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign Ev_Valid = valid_q;
    assign Ev_Seq   = seq_q;
    assign Pending  = pend_q;
    assign Overflow = ovf_q;
    assign Busy     = busy_q;

endmodule
